// File: rtl/sand_pkg.sv
// Shared constants and types for the sand painting datapath.
// Cell values, mouse button indices and the brush painter FSM states.
package sand_pkg;

    localparam logic SAND  = 1'b1;
    localparam logic EMPTY = 1'b0;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        PAINT,
        DONE
    } painter_state_t;

endpackage

// File: rtl/brush_address_generator.sv
// Walks the brush square cell by cell: dx/dy counters, running row address,
// on-screen clip test and last-cell flag. Only additions; the multiply lives in the top.
module brush_address_generator #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = 19,
    parameter int BRUSH_SIZE     = 4,
    parameter int X_WIDTH        = 10,
    parameter int Y_WIDTH        = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [X_WIDTH-1:0]    anchor_x,
    input  logic [Y_WIDTH-1:0]    anchor_y,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] cell_address,
    output logic                  in_range,
    output logic                  last_cell
);

    localparam int CW = (BRUSH_SIZE > 1) ? $clog2(BRUSH_SIZE) : 1;
    localparam int XC = X_WIDTH + 1;
    localparam int YC = Y_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(BRUSH_SIZE - 1);

    logic [CW-1:0]         dx;
    logic [CW-1:0]         dy;
    logic [X_WIDTH-1:0]    x0;
    logic [Y_WIDTH-1:0]    y0;
    logic [ADDR_WIDTH-1:0] row_addr;
    logic [XC-1:0]         x_sum;
    logic [YC-1:0]         y_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            dx       <= '0;
            dy       <= '0;
            x0       <= '0;
            y0       <= '0;
            row_addr <= '0;
        end else if (load) begin
            dx       <= '0;
            dy       <= '0;
            x0       <= anchor_x;
            y0       <= anchor_y;
            row_addr <= base;
        end else if (step) begin
            if (dx == LAST) begin
                dx       <= '0;
                dy       <= dy + 1'b1;
                row_addr <= row_addr + ADDR_WIDTH'(ACTIVE_COLUMNS);
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

    // One extra bit so a cell just past the right/bottom edge cannot wrap back on-screen.
    assign x_sum        = {1'b0, x0} + XC'(dx);
    assign y_sum        = {1'b0, y0} + YC'(dy);
    assign in_range     = (x_sum < XC'(ACTIVE_COLUMNS)) && (y_sum < YC'(ACTIVE_ROWS));
    assign cell_address = row_addr + ADDR_WIDTH'(dx);
    assign last_cell    = (dx == LAST) && (dy == LAST);

endmodule

// File: rtl/sand_brush_painter.sv
// Turns completed mouse packets with a button held into a square brush of RAM writes,
// borrowing the game-state RAM write port from the controller for the duration of a stroke.
module sand_brush_painter
    import sand_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int BRUSH_SIZE     = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [$clog2(ACTIVE_COLUMNS)-1:0] mouse_x_i,
    input  logic [$clog2(ACTIVE_ROWS)-1:0]    mouse_y_i,
    input  logic [2:0]                        btn_i,
    input  logic                              mouse_done_i,
    input  logic                              grant_i,
    output logic                              req_o,
    output logic                              wr_en_o,
    output logic [ADDR_WIDTH-1:0]             wr_address_o,
    output logic [DATA_WIDTH-1:0]             wr_data_o,
    output logic                              busy_o
);

    localparam int X_WIDTH = $clog2(ACTIVE_COLUMNS);
    localparam int Y_WIDTH = $clog2(ACTIVE_ROWS);

    painter_state_t        state;
    painter_state_t        state_next;
    logic                  req_next;
    logic                  wr_en_next;
    logic                  busy_next;
    logic [ADDR_WIDTH-1:0] address_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic [DATA_WIDTH-1:0] value_q;
    logic [DATA_WIDTH-1:0] value_next;
    logic                  accept;
    logic                  load;
    logic                  step;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] cell_address;
    logic                  in_range;
    logic                  last_cell;
    logic                  middle_unused;

    assign middle_unused = btn_i[2];

    assign accept = (state == IDLE) && !busy_o && mouse_done_i
                  && (btn_i[BTN_LEFT] || btn_i[BTN_RIGHT]);
    assign base   = ADDR_WIDTH'(mouse_y_i) * ADDR_WIDTH'(ACTIVE_COLUMNS) + ADDR_WIDTH'(mouse_x_i);

    brush_address_generator #(
        .ACTIVE_COLUMNS(ACTIVE_COLUMNS),
        .ACTIVE_ROWS   (ACTIVE_ROWS),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BRUSH_SIZE    (BRUSH_SIZE),
        .X_WIDTH       (X_WIDTH),
        .Y_WIDTH       (Y_WIDTH)
    ) u_brush_address_generator (
        .clk         (clk_i),
        .reset       (reset_i),
        .load        (load),
        .base        (base),
        .anchor_x    (mouse_x_i),
        .anchor_y    (mouse_y_i),
        .step        (step),
        .cell_address(cell_address),
        .in_range    (in_range),
        .last_cell   (last_cell)
    );

    // Handshake: req_o stays high from REQ through the final PAINT cycle. A cell is
    // consumed only on an edge where req_o=1 and grant_i=1; grant_i low just pauses the walk.
    always_comb begin
        state_next   = state;
        req_next     = 1'b0;
        wr_en_next   = 1'b0;
        address_next = wr_address_o;
        data_next    = wr_data_o;
        value_next   = value_q;
        load         = 1'b0;
        step         = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    value_next = btn_i[BTN_LEFT] ? DATA_WIDTH'(SAND) : DATA_WIDTH'(EMPTY);
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                req_next = 1'b1;
                if (grant_i) state_next = PAINT;
            end
            PAINT: begin
                req_next = 1'b1;
                if (grant_i) begin
                    step = 1'b1;
                    if (in_range) begin
                        wr_en_next   = 1'b1;
                        address_next = cell_address;
                        data_next    = value_q;
                    end
                    if (last_cell) begin
                        req_next   = 1'b0;
                        state_next = DONE;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // busy_o lingers for the first IDLE cycle, so packets are refused until it drops.
        busy_next = (state_next != IDLE) || (state != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            req_o        <= 1'b0;
            wr_en_o      <= 1'b0;
            wr_address_o <= '0;
            wr_data_o    <= '0;
            busy_o       <= 1'b0;
            value_q      <= '0;
        end else begin
            state        <= state_next;
            req_o        <= req_next;
            wr_en_o      <= wr_en_next;
            wr_address_o <= address_next;
            wr_data_o    <= data_next;
            busy_o       <= busy_next;
            value_q      <= value_next;
        end
    end

endmodule

// File: tb/tb_sand_brush_painter.sv
// Self-checking bench for sand_brush_painter: directed strokes plus randomized strokes
// scored against a cell-list model of the brush.
module tb_sand_brush_painter;

  localparam int COLS  = 640;
  localparam int ROWS  = 480;
  localparam int AW    = 19;
  localparam int BRUSH = 4;
  localparam int W     = AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    mouse_x;
  logic [8:0]    mouse_y;
  logic [2:0]    btn;
  logic          mouse_done;
  logic          grant;
  logic          req_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_address_o;
  logic [0:0]    wr_data_o;
  logic          busy_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int writes_seen = 0;

  sand_brush_painter dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .mouse_x_i   (mouse_x),
    .mouse_y_i   (mouse_y),
    .btn_i       (btn),
    .mouse_done_i(mouse_done),
    .grant_i     (grant),
    .req_o       (req_o),
    .wr_en_o     (wr_en_o),
    .wr_address_o(wr_address_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: every on-screen cell of the brush, row-major, all with the stroke value
  function automatic int model_push(input int x, input int y, input logic [2:0] b);
    int n;
    logic [AW-1:0] a;
    logic d;
    n = 0;
    d = b[0] ? 1'b1 : 1'b0;
    for (int dy = 0; dy < BRUSH; dy++) begin
      for (int dx = 0; dx < BRUSH; dx++) begin
        if (x + dx < COLS && y + dy < ROWS) begin
          a = AW'((y + dy) * COLS + x + dx);
          exp_q.push_back({a, d});
          n++;
        end
      end
    end
    return n;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (wr_en_o) begin
      writes_seen++;
      check_eq("addr_in_range", 32'(wr_address_o < AW'(COLS * ROWS)), 1);
      if (exp_q.size() == 0) begin
        check_eq("write_without_expectation", 32'(wr_en_o), 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("write_addr", 32'(wr_address_o), 32'(e[W-1:1]));
        check_eq("write_data", 32'(wr_data_o), 32'(e[0]));
      end
    end
  end

  // driver tasks
  task automatic send_packet(input int x, input int y, input logic [2:0] b);
    @(negedge clk);
    mouse_x    = 10'(x);
    mouse_y    = 9'(y);
    btn        = b;
    mouse_done = 1'b1;
    @(negedge clk);
    mouse_done = 1'b0;
  endtask

  task automatic stroke_fixed(input int x, input int y, input logic [2:0] b, input string name);
    int w0, nexp;
    grant = 1'b1;
    w0 = writes_seen;
    nexp = model_push(x, y, b);
    send_packet(x, y, b);
    check_eq({name, "_req_k1"}, 32'(req_o), 1);
    @(negedge clk);
    check_eq({name, "_wr_en_k2"}, 32'(wr_en_o), 0);
    @(negedge clk);
    check_eq({name, "_first_write_k3"}, 32'(wr_en_o), 1);
    repeat (15) @(negedge clk);
    check_eq({name, "_busy_k18"}, 32'(busy_o), 1);
    check_eq({name, "_req_done"}, 32'(req_o), 0);
    repeat (2) @(negedge clk);
    check_eq({name, "_busy_k20"}, 32'(busy_o), 0);
    check_eq({name, "_write_count"}, 32'(writes_seen - w0), 32'(nexp));
    check_eq({name, "_queue_drained"}, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_idle(input string name, input int budget, input bit random_grant);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      if (random_grant) grant = ($urandom_range(0, 3) != 0);
      n++;
    end
    check_eq({name, "_finished"}, 32'(busy_o), 0);
    grant = 1'b1;
  endtask

  task automatic stroke_random(input int idx);
    int x, y, w0, nexp;
    logic [2:0] b;
    x = $urandom_range(0, 1) ? $urandom_range(632, 639) : $urandom_range(0, 639);
    y = $urandom_range(0, 1) ? $urandom_range(472, 479) : $urandom_range(0, 479);
    b = 3'($urandom_range(1, 3)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000);
    w0 = writes_seen;
    nexp = model_push(x, y, b);
    grant = ($urandom_range(0, 3) != 0);
    send_packet(x, y, b);
    wait_idle($sformatf("rand%0d", idx), 400, 1'b1);
    check_eq($sformatf("rand%0d_write_count", idx), 32'(writes_seen - w0), 32'(nexp));
  endtask

  initial begin
    int cnt, w0;
    logic [AW-1:0] held;
    bit stalled;

    // reset
    reset = 1'b1; mouse_x = '0; mouse_y = '0; btn = '0; mouse_done = 1'b0; grant = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_req", 32'(req_o), 0);
    check_eq("reset_wr_en", 32'(wr_en_o), 0);
    check_eq("reset_addr", 32'(wr_address_o), 0);
    check_eq("reset_data", 32'(wr_data_o), 0);
    check_eq("reset_busy", 32'(busy_o), 0);

    // directed strokes with grant held high
    stroke_fixed(10, 20, 3'b001, "basic");
    stroke_fixed(638, 0, 3'b010, "right_clip");
    stroke_fixed(639, 479, 3'b011, "corner_clip");

    // grant stall after the third write
    w0 = writes_seen; cnt = 0; stalled = 1'b0; held = '0;
    void'(model_push(200, 100, 3'b001));
    grant = 1'b1;
    send_packet(200, 100, 3'b001);
    for (int i = 0; i < 60 && busy_o; i++) begin
      @(negedge clk);
      if (wr_en_o) begin cnt++; held = wr_address_o; end
      if (cnt == 3 && !stalled) begin
        grant = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_wr_en", 32'(wr_en_o), 0);
          check_eq("stall_addr_held", 32'(wr_address_o), 32'(held));
        end
        grant = 1'b1;
        stalled = 1'b1;
      end
    end
    check_eq("stall_finished", 32'(busy_o), 0);
    check_eq("stall_write_count", 32'(writes_seen - w0), 16);

    // second packet during PAINT is dropped
    w0 = writes_seen;
    void'(model_push(300, 200, 3'b010));
    send_packet(300, 200, 3'b010);
    repeat (4) @(negedge clk);
    send_packet(50, 50, 3'b001);
    wait_idle("drop", 60, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("drop_write_count", 32'(writes_seen - w0), 16);
    check_eq("drop_req_idle", 32'(req_o), 0);

    // reset after the sixth write abandons the stroke
    void'(model_push(400, 300, 3'b001));
    send_packet(400, 300, 3'b001);
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 6; i++) begin
      @(negedge clk);
      if (wr_en_o) cnt++;
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("midreset_req", 32'(req_o), 0);
    check_eq("midreset_wr_en", 32'(wr_en_o), 0);
    check_eq("midreset_addr", 32'(wr_address_o), 0);
    check_eq("midreset_data", 32'(wr_data_o), 0);
    check_eq("midreset_busy", 32'(busy_o), 0);
    reset = 1'b0;
    exp_q.delete();
    w0 = writes_seen;
    repeat (25) @(negedge clk);
    check_eq("midreset_no_writes", 32'(writes_seen - w0), 0);

    // middle-button-only packet is ignored
    send_packet(5, 5, 3'b100);
    repeat (3) begin
      check_eq("middle_req", 32'(req_o), 0);
      check_eq("middle_busy", 32'(busy_o), 0);
      @(negedge clk);
    end

    // randomized strokes with random grant gaps
    for (int i = 0; i < 25; i++) stroke_random(i);
    check_eq("final_queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
